wb_stage_pipe: RTL and testbench

Registered, parametrised writeback stage for the MIPS pipeline. It selects the writeback source (memory, ALU, or link PC+8) and aligns and extends sub-word loads (byte, half, word, with sign or zero extension). It registers the register-file write request and provides stall/flush control, a sticky halt, and a retired-instruction counter. It sits between the MEM/WB boundary and the register file write port.

---
 rtl/wb_stage_pipe.sv | 155 +++++++++++++++
 tb/tb_wb_stage_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_pipe.sv
// Writeback stage: selects the writeback source, aligns and extends sub-word
// loads, and registers the register-file write request. Also provides
// stall/flush handling, a sticky halt flag and a saturating retired-instruction
// counter.
module wb_stage_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32,
    localparam int unsigned OFF_W     = $clog2(DATA_W / 8)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [DATA_W-1:0]     i_mem_data,
    input  logic [DATA_W-1:0]     i_alu_result,
    input  logic [DATA_W-1:0]     i_pc_plus_8,
    input  logic                  i_mem_to_reg,
    input  logic                  i_is_jal,
    input  logic [1:0]            i_load_size,
    input  logic                  i_load_unsigned,
    input  logic [OFF_W-1:0]      i_byte_offset,
    input  logic                  i_reg_write,
    input  logic [REG_ADDR_W-1:0] i_rd,
    input  logic                  i_halt,
    output logic [DATA_W-1:0]     o_write_data,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic                  o_reg_write,
    output logic                  o_valid,
    output logic                  o_halt,
    output logic [CNT_W-1:0]      o_retired_count
);

    logic [OFF_W-1:0]      lane_off;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     load_val;
    logic [DATA_W-1:0]     wb_sel;
    int unsigned           load_width;
    logic                  fill;

    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic                  reg_write_q, reg_write_d;
    logic                  valid_q, valid_d;
    logic                  halt_q, halt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Load alignment: clear offset bits below the access size, shift the lane
    // down to bit 0, then zero- or sign-extend above the access width.
    always_comb begin
        lane_off   = '0;
        load_width = DATA_W;
        fill       = 1'b0;
        shifted    = '0;
        load_val   = '0;
        unique case (i_load_size)
            2'b00: begin
                lane_off   = i_byte_offset;
                load_width = 8;
            end
            2'b01: begin
                lane_off   = i_byte_offset & ~OFF_W'(1);
                load_width = 16;
            end
            2'b10: begin
                lane_off   = i_byte_offset & ~OFF_W'(3);
                load_width = 32;
            end
            default: begin
                lane_off   = '0;
                load_width = DATA_W;
            end
        endcase
        shifted = i_mem_data >> {lane_off, 3'b000};
        unique case (i_load_size)
            2'b00:   fill = ~i_load_unsigned & shifted[7];
            2'b01:   fill = ~i_load_unsigned & shifted[15];
            2'b10:   fill = ~i_load_unsigned & shifted[31];
            default: fill = 1'b0;
        endcase
        load_val = shifted;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i >= load_width) begin
                load_val[i] = fill;
            end
        end
    end

    // Writeback source select; the link address overrides everything.
    always_comb begin
        wb_sel = i_alu_result;
        if (i_is_jal) begin
            wb_sel = i_pc_plus_8;
        end else if (i_mem_to_reg) begin
            wb_sel = load_val;
        end
    end

    // Next-state: halted > flush > stall > normal capture.
    always_comb begin
        write_data_d = write_data_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        valid_d      = valid_q;
        halt_d       = halt_q;
        cnt_d        = cnt_q;
        if (halt_q) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (i_flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!i_stall) begin
            write_data_d = wb_sel;
            rd_d         = i_rd;
            valid_d      = i_valid;
            reg_write_d  = i_valid & i_reg_write & (i_rd != '0);
            if (i_valid && i_halt) begin
                halt_d      = 1'b1;
                reg_write_d = 1'b0;
            end
            if (i_valid && !i_halt && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            write_data_q <= '0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            valid_q      <= 1'b0;
            halt_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            valid_q      <= valid_d;
            halt_q       <= halt_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_write_data    = write_data_q;
    assign o_rd            = rd_q;
    assign o_reg_write     = reg_write_q;
    assign o_valid         = valid_q;
    assign o_halt          = halt_q;
    assign o_retired_count = cnt_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Bench for wb_stage_pipe: a 32-bit counter instance and a 3-bit counter
// instance share all inputs; expected outputs are queued per driven slot and
// compared one cycle later.
module tb_wb_stage_pipe;

    logic        clk;
    logic        i_reset, i_valid, i_stall, i_flush;
    logic [31:0] i_mem_data, i_alu_result, i_pc_plus_8;
    logic        i_mem_to_reg, i_is_jal, i_load_unsigned, i_reg_write, i_halt;
    logic [1:0]  i_load_size, i_byte_offset;
    logic [4:0]  i_rd;

    logic [31:0] o_write_data, o_retired_count;
    logic [4:0]  o_rd;
    logic        o_reg_write, o_valid, o_halt;

    logic [31:0] s_write_data;
    logic [2:0]  s_retired_count;
    logic [4:0]  s_rd;
    logic        s_reg_write, s_valid, s_halt;

    int n_checks = 0;
    int n_fail   = 0;
    int m_cnt    = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
        logic [2:0]  sat;
        logic        chk_data;
    } exp_t;

    typedef struct {
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] pc8;
        logic        m2r;
        logic        jal;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_rw;
    } vec_t;

    exp_t sb[$];
    vec_t vt[15];

    wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) u_dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_flush(i_flush), .i_mem_data(i_mem_data), .i_alu_result(i_alu_result),
        .i_pc_plus_8(i_pc_plus_8), .i_mem_to_reg(i_mem_to_reg), .i_is_jal(i_is_jal),
        .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned),
        .i_byte_offset(i_byte_offset), .i_reg_write(i_reg_write), .i_rd(i_rd),
        .i_halt(i_halt), .o_write_data(o_write_data), .o_rd(o_rd),
        .o_reg_write(o_reg_write), .o_valid(o_valid), .o_halt(o_halt),
        .o_retired_count(o_retired_count)
    );

    wb_stage_pipe #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(3)) u_sat (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_flush(i_flush), .i_mem_data(i_mem_data), .i_alu_result(i_alu_result),
        .i_pc_plus_8(i_pc_plus_8), .i_mem_to_reg(i_mem_to_reg), .i_is_jal(i_is_jal),
        .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned),
        .i_byte_offset(i_byte_offset), .i_reg_write(i_reg_write), .i_rd(i_rd),
        .i_halt(i_halt), .o_write_data(s_write_data), .o_rd(s_rd),
        .o_reg_write(s_reg_write), .o_valid(s_valid), .o_halt(s_halt),
        .o_retired_count(s_retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Queue the expected outputs for the slot currently on the inputs.
    task automatic expect_out(input logic [31:0] data, input logic [4:0] rd, input logic rw,
                              input logic valid, input logic halt, input logic chkd);
        exp_t e;
        e.data     = data;
        e.rd       = rd;
        e.rw       = rw;
        e.valid    = valid;
        e.halt     = halt;
        e.cnt      = m_cnt;
        e.sat      = (m_cnt > 7) ? 3'd7 : 3'(m_cnt);
        e.chk_data = chkd;
        sb.push_back(e);
    endtask

    // Advance one edge, then pop and compare.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            if (e.chk_data) begin
                chk("write_data", o_write_data, e.data);
                chk("rd", o_rd, e.rd);
            end
            chk("reg_write", o_reg_write, e.rw);
            chk("valid", o_valid, e.valid);
            chk("halt", o_halt, e.halt);
            chk("retired_count", o_retired_count, e.cnt);
            chk("sat_count", s_retired_count, e.sat);
            chk("sat_halt", s_halt, e.halt);
        end
    endtask

    task automatic drive_alu(input logic valid, input logic halt, input logic [31:0] alu,
                             input logic [4:0] rd, input logic rw);
        i_valid      = valid;
        i_halt       = halt;
        i_alu_result = alu;
        i_rd         = rd;
        i_reg_write  = rw;
        i_mem_to_reg = 1'b0;
        i_is_jal     = 1'b0;
    endtask

    initial begin
        vt[0]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b00, 0, 2'd0, 1, 5'd3, 32'hFFFF_FFA5, 1};
        vt[1]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b00, 1, 2'd0, 1, 5'd3, 32'h0000_00A5, 1};
        vt[2]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b01, 0, 2'd2, 1, 5'd3, 32'hFFFF_8000, 1};
        vt[3]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b01, 1, 2'd2, 1, 5'd3, 32'h0000_8000, 1};
        vt[4]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b10, 0, 2'd0, 1, 5'd3, 32'h8000_F0A5, 1};
        vt[5]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b00, 0, 2'd1, 1, 5'd3, 32'hFFFF_FFF0, 1};
        vt[6]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b00, 0, 2'd2, 1, 5'd3, 32'h0000_0000, 1};
        vt[7]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b00, 1, 2'd3, 1, 5'd3, 32'h0000_0080, 1};
        vt[8]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b01, 0, 2'd3, 1, 5'd3, 32'hFFFF_8000, 1};
        vt[9]  = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b01, 1, 2'd0, 1, 5'd3, 32'h0000_F0A5, 1};
        vt[10] = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b10, 0, 2'd3, 1, 5'd3, 32'h8000_F0A5, 1};
        vt[11] = '{32'h8000_F0A5, 32'h0, 32'h0, 1, 0, 2'b11, 0, 2'd1, 1, 5'd3, 32'h8000_F0A5, 1};
        vt[12] = '{32'h8000_F0A5, 32'h77, 32'h108, 1, 1, 2'b00, 0, 2'd0, 1, 5'd3, 32'h0000_0108, 1};
        vt[13] = '{32'h8000_F0A5, 32'hDEAD, 32'h0, 0, 0, 2'b00, 0, 2'd0, 1, 5'd0, 32'h0000_DEAD, 0};
        vt[14] = '{32'h8000_F0A5, 32'h1, 32'h0, 0, 0, 2'b00, 0, 2'd0, 0, 5'd9, 32'h0000_0001, 0};

        i_reset = 1'b1; i_valid = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_mem_data = '0; i_alu_result = '0; i_pc_plus_8 = '0;
        i_mem_to_reg = 1'b0; i_is_jal = 1'b0; i_load_size = 2'b00;
        i_load_unsigned = 1'b0; i_byte_offset = '0; i_reg_write = 1'b0;
        i_rd = '0; i_halt = 1'b0;

        // Reset for two cycles, then idle bubbles.
        m_cnt = 0;
        repeat (2) begin
            expect_out(32'h0, 5'd0, 0, 0, 0, 1);
            step();
        end
        i_reset = 1'b0;
        repeat (5) begin
            expect_out(32'h0, 5'd0, 0, 0, 0, 1);
            step();
        end

        // Table-driven load extraction and source selection.
        for (int k = 0; k < 15; k++) begin
            i_valid         = 1'b1;
            i_halt          = 1'b0;
            i_mem_data      = vt[k].mem;
            i_alu_result    = vt[k].alu;
            i_pc_plus_8     = vt[k].pc8;
            i_mem_to_reg    = vt[k].m2r;
            i_is_jal        = vt[k].jal;
            i_load_size     = vt[k].size;
            i_load_unsigned = vt[k].uns;
            i_byte_offset   = vt[k].off;
            i_reg_write     = vt[k].rw;
            i_rd            = vt[k].rd;
            m_cnt++;
            expect_out(vt[k].exp_data, vt[k].rd, vt[k].exp_rw, 1, 0, 1);
            step();
        end

        // Stall holds a captured write; flush (with or without stall) bubbles.
        drive_alu(1, 0, 32'h1234, 5'd5, 1);
        m_cnt++;
        expect_out(32'h1234, 5'd5, 1, 1, 0, 1);
        step();
        drive_alu(1, 0, 32'h9999, 5'd7, 1);
        i_stall = 1'b1;
        repeat (3) begin
            expect_out(32'h1234, 5'd5, 1, 1, 0, 1);
            step();
        end
        i_flush = 1'b1;
        expect_out(32'h0, 5'd0, 0, 0, 0, 0);
        step();
        i_stall = 1'b0;
        expect_out(32'h0, 5'd0, 0, 0, 0, 0);
        step();
        i_flush = 1'b0;
        m_cnt++;
        expect_out(32'h9999, 5'd7, 1, 1, 0, 1);
        step();

        // Halt is sticky, freezes data/rd and the counter, and ignores later slots.
        i_reset = 1'b1;
        m_cnt = 0;
        expect_out(32'h0, 5'd0, 0, 0, 0, 1);
        step();
        i_reset = 1'b0;
        drive_alu(1, 0, 32'h11, 5'd1, 1);
        m_cnt++;
        expect_out(32'h11, 5'd1, 1, 1, 0, 1);
        step();
        drive_alu(1, 0, 32'h22, 5'd2, 1);
        m_cnt++;
        expect_out(32'h22, 5'd2, 1, 1, 0, 1);
        step();
        drive_alu(1, 1, 32'h33, 5'd4, 1);
        expect_out(32'h33, 5'd4, 0, 1, 1, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive_alu(1, 0, 32'h44 + 32'(k), 5'd6, 1);
            i_stall = (k == 1);
            i_flush = (k == 2);
            expect_out(32'h33, 5'd4, 0, 0, 1, 1);
            step();
        end
        i_stall = 1'b0;
        i_flush = 1'b0;
        i_reset = 1'b1;
        m_cnt = 0;
        expect_out(32'h0, 5'd0, 0, 0, 0, 1);
        step();
        i_reset = 1'b0;

        // Nine retirements: the 3-bit counter saturates at 7.
        for (int k = 1; k <= 9; k++) begin
            drive_alu(1, 0, 32'(k), 5'd1, 1);
            m_cnt++;
            expect_out(32'(k), 5'd1, 1, 1, 0, 1);
            step();
        end
        chk("sat_final", s_retired_count, 3'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
